cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one physical-memory line port (256-bit burst interface) between the I-cache and D-cache
//  miss paths. Grants one requester at a time, round-robin on simultaneous requests; registers the
//  granted address/data onto the memory port and routes rdata/resp back to the winner only.
//  Sits between the two caches (each behind its own 32->256 line adapter) and the memory model.
// PARAMETERS
//  ADDR_W  32   byte address width; line-aligned, bits [4:0] passed through unchanged
//  LINE_W  256  cache line width in bits
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst_n           in   1       asynchronous active-low reset
//  i_pmem_read     in   1       I-cache line read request, held until i_pmem_resp
//  i_pmem_address  in   ADDR_W  I-cache line address
//  i_pmem_rdata    out  LINE_W  line returned to I-cache
//  i_pmem_resp     out  1       I-cache transaction complete (1-cycle pulse)
//  d_pmem_read     in   1       D-cache line read request (refill)
//  d_pmem_write    in   1       D-cache line write request (writeback); never with d_pmem_read
//  d_pmem_address  in   ADDR_W  D-cache line address
//  d_pmem_wdata    in   LINE_W  D-cache writeback line
//  d_pmem_rdata    out  LINE_W  line returned to D-cache
//  d_pmem_resp     out  1       D-cache transaction complete (1-cycle pulse)
//  pmem_read       out  1       memory read strobe, held until pmem_resp
//  pmem_write      out  1       memory write strobe, held until pmem_resp
//  pmem_address    out  ADDR_W  memory address (registered)
//  pmem_wdata      out  LINE_W  memory write line (registered)
//  pmem_rdata      in   LINE_W  memory read line, valid with pmem_resp
//  pmem_resp       in   1       memory transaction complete (1-cycle pulse)
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=D (so I wins first tie), pmem_read/write=0, pmem_address=0,
//    pmem_wdata=0; i/d_pmem_resp=0 whenever not in the matching serve state.
//  - States: IDLE, SERVE_I, SERVE_D, DONE.
//  - IDLE: req_i=i_pmem_read, req_d=d_pmem_read|d_pmem_write. Only one -> grant it. Both -> grant
//    the one != last_grant. On grant edge: latch address (and d wdata, op type) into pmem_* regs,
//    assert pmem_read/pmem_write from next cycle, update last_grant. Neither -> stay, strobes 0.
//  - SERVE_x: strobes held stable; latched regs ignore requester changes. On pmem_resp=1:
//    x_pmem_resp=1 combinationally same cycle, x_pmem_rdata=pmem_rdata; the other side's resp=0.
//    Next edge -> DONE, strobes drop to 0.
//  - DONE: one bubble cycle (requester deasserts its request); -> IDLE. No grant in DONE.
//  - Latency: request seen in IDLE at edge N -> pmem strobe high N+1; min. turnaround resp->next
//    grant strobe = 3 cycles (DONE, IDLE grant, strobe).
//  - x_pmem_rdata driven from pmem_rdata at all times (valid only with resp); no data register.
//  - Requester dropping its request mid-SERVE: transaction still completes on memory; resp pulse
//    still issued; arbiter never aborts a memory transaction except by reset.
//  - d_pmem_read & d_pmem_write both 1: illegal; RTL asserts (simulation), treats as write.
//  - pmem_resp outside SERVE_x: ignored, no resp forwarded.
//  - Reset mid-SERVE: strobes drop asynchronously, state IDLE; memory model must be reset alongside.
//  - Fairness: a continuously requesting side waits at most one other transaction.
// STRUCTURE
//  - cache_arb_pkg: arb_state_e {IDLE,SERVE_I,SERVE_D,DONE}, requester_e {REQ_I,REQ_D},
//    localparams ARB_ADDR_W=32, ARB_LINE_W=256.
//  - One FSM + grant register in this module; no sub-module (2-way round-robin is one flop).
// TESTING
//  - Reset, no requests 20 cycles -> pmem_read=pmem_write=0, both resps 0, state IDLE.
//  - I read 0x0000_1000 alone; memory resp after 5 cycles with line 0xA5..A5 -> pmem_read 1 for
//    exactly those cycles, pmem_address=0x1000, i_pmem_resp one pulse, i_pmem_rdata=0xA5..A5,
//    d_pmem_resp never 1.
//  - I read 0x100 and D write 0x200 (wdata 0xDEAD..BEEF) same cycle after reset -> I served first,
//    then D: pmem_write=1, pmem_address=0x200, pmem_wdata=0xDEAD..BEEF.
//  - Both request continuously 6 transactions -> grants alternate I,D,I,D,I,D; 1 DONE bubble each.
//  - D changes d_pmem_address 0x300->0x400 mid-SERVE_D -> pmem_address stays 0x300 until resp.
//  - rst_n low mid-SERVE_I -> pmem_read 0 immediately (async); after release, fresh D request
//    granted normally; spurious pmem_resp in IDLE produces no i/d resp.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory line-port arbiter.
package cache_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

  // 2-way round robin: on a tie the side that did not win last time goes next.
  function automatic requester_e pick_winner(input logic req_i, input logic req_d,
                                             input requester_e last_grant);
    requester_e w;
    if (req_i && req_d) begin
      w = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      w = REQ_D;
    end else begin
      w = REQ_I;
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Line-port bundle between the two cache miss paths, the arbiter and physical memory.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = cache_arb_pkg::ARB_ADDR_W,
  parameter int LINE_W = cache_arb_pkg::ARB_LINE_W
);

  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter view.
  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Environment view (caches plus memory).
  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin I/D-cache arbiter for one memory line port; strobe 1 cycle after grant, resp routed same cycle.
// Requesters hold their request until resp; one DONE bubble between transactions, never aborts except on reset.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  requester_e        last_grant;
  requester_e        winner;
  logic              req_i;
  logic              req_d;
  logic              grant;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  always_comb begin
    req_i  = bus.i_pmem_read;
    req_d  = bus.d_pmem_read | bus.d_pmem_write;
    winner = pick_winner(req_i, req_d, last_grant);
    grant  = (state == IDLE) && (req_i || req_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = (winner == REQ_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only on the grant edge, so requester changes mid-serve are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_D;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant) begin
      last_grant <= winner;
      if (winner == REQ_I) begin
        op_write <= 1'b0;
        addr_q   <= bus.i_pmem_address;
      end else begin
        op_write <= bus.d_pmem_write;
        addr_q   <= bus.d_pmem_address;
        wdata_q  <= bus.d_pmem_wdata;
      end
    end
  end

  always_comb begin
    bus.pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
    bus.pmem_write   = (state == SERVE_D) && op_write;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_pmem_resp  = (state == SERVE_I) && bus.pmem_resp;
    bus.d_pmem_resp  = (state == SERVE_D) && bus.pmem_resp;
    bus.i_pmem_rdata = bus.pmem_rdata;
    bus.d_pmem_rdata = bus.pmem_rdata;
  end

  // Simultaneous refill and writeback from the D side is illegal; the write wins if it happens.
  rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(bus.d_pmem_read && bus.d_pmem_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a scripted memory responder and hand-computed expectations.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   waited;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the memory strobe, then checks the granted request.
  task automatic wait_grant(input string tag, input logic exp_rd, input logic exp_wr,
                            input logic [31:0] exp_addr, input logic [255:0] exp_wd,
                            output int n);
    n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus.pmem_read || bus.pmem_write)) begin
      chk({tag, "_grant_timeout"}, 256'd0, 256'd1);
    end else begin
      chk({tag, "_rd"}, bus.pmem_read, exp_rd);
      chk({tag, "_wr"}, bus.pmem_write, exp_wr);
      chk({tag, "_addr"}, bus.pmem_address, exp_addr);
      if (exp_wr) chk({tag, "_wdata"}, bus.pmem_wdata, exp_wd);
    end
  endtask

  // Strobes and address must stay put while memory is busy.
  task automatic hold(input string tag, input int n, input logic exp_rd, input logic exp_wr,
                      input logic [31:0] exp_addr);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_hold_strobes"}, {bus.pmem_read, bus.pmem_write}, {exp_rd, exp_wr});
      chk({tag, "_hold_addr"}, bus.pmem_address, exp_addr);
      chk({tag, "_hold_resps"}, {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
    end
  endtask

  // Memory completes now; side 0 = I, 1 = D. Leaves the bench in the DONE cycle.
  task automatic respond(input string tag, input logic side, input logic [255:0] line);
    bus.pmem_rdata = line;
    bus.pmem_resp  = 1'b1;
    #1;
    chk({tag, "_resp"}, {bus.i_pmem_resp, bus.d_pmem_resp}, side ? 2'b01 : 2'b10);
    chk({tag, "_rdata"}, side ? bus.d_pmem_rdata : bus.i_pmem_rdata, line);
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    #1;
    chk({tag, "_done_strobes"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk({tag, "_done_resps"}, {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
    chk({tag, "_done_state"}, dut.state, DONE);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    do_reset();

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      chk("idle_outputs", {bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp}, 4'b0000);
      tick();
    end
    chk("idle_state", dut.state, IDLE);
    chk("idle_addr", bus.pmem_address, 32'h0);
    chk("idle_wdata", bus.pmem_wdata, 256'h0);

    // Lone I read, memory answers on the fifth strobe cycle.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1000;
    wait_grant("i_alone", 1'b1, 1'b0, 32'h0000_1000, '0, waited);
    chk("i_alone_latency", waited, 1);
    hold("i_alone", 4, 1'b1, 1'b0, 32'h0000_1000);
    respond("i_alone", 1'b0, {32{8'hA5}});
    bus.i_pmem_read = 1'b0;

    // Simultaneous I read and D write straight after reset: I first.
    do_reset();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0100;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_0200;
    bus.d_pmem_wdata   = {8{32'hDEAD_BEEF}};
    wait_grant("tie_i", 1'b1, 1'b0, 32'h0000_0100, '0, waited);
    hold("tie_i", 1, 1'b1, 1'b0, 32'h0000_0100);
    respond("tie_i", 1'b0, {8{32'h1111_2222}});
    bus.i_pmem_read = 1'b0;
    wait_grant("tie_d", 1'b0, 1'b1, 32'h0000_0200, {8{32'hDEAD_BEEF}}, waited);
    chk("tie_d_turnaround", waited, 2);
    hold("tie_d", 2, 1'b0, 1'b1, 32'h0000_0200);
    respond("tie_d", 1'b1, {32{8'h5A}});
    bus.d_pmem_write = 1'b0;
    tick();

    // Both sides request continuously: strict alternation starting with I.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1100;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_2200;
    for (int k = 0; k < 6; k++) begin
      logic side;
      side = logic'(k % 2);
      wait_grant(side ? "rr_d" : "rr_i", 1'b1, 1'b0, side ? 32'h0000_2200 : 32'h0000_1100, '0, waited);
      if (k > 0) chk("rr_turnaround", waited, 2);
      respond(side ? "rr_d" : "rr_i", side, {32{8'(k + 1)}});
    end
    bus.i_pmem_read = 1'b0;
    bus.d_pmem_read = 1'b0;
    tick();

    // Requester changes its address and data mid-serve; latched values must not move.
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_0300;
    bus.d_pmem_wdata   = {8{32'h0BAD_F00D}};
    wait_grant("midchg", 1'b0, 1'b1, 32'h0000_0300, {8{32'h0BAD_F00D}}, waited);
    bus.d_pmem_address = 32'h0000_0400;
    bus.d_pmem_wdata   = {8{32'h1234_5678}};
    hold("midchg", 3, 1'b0, 1'b1, 32'h0000_0300);
    chk("midchg_wdata", bus.pmem_wdata, {8{32'h0BAD_F00D}});
    respond("midchg", 1'b1, {32{8'h3C}});
    bus.d_pmem_write = 1'b0;
    tick();

    // Asynchronous reset in the middle of an I transaction.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0600;
    wait_grant("rst_mid", 1'b1, 1'b0, 32'h0000_0600, '0, waited);
    hold("rst_mid", 1, 1'b1, 1'b0, 32'h0000_0600);
    #2;
    rst_n = 1'b0;
    bus.i_pmem_read = 1'b0;
    #1;
    chk("rst_mid_read_drop", bus.pmem_read, 1'b0);
    chk("rst_mid_state", dut.state, IDLE);
    chk("rst_mid_addr", bus.pmem_address, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0700;
    wait_grant("post_rst_d", 1'b1, 1'b0, 32'h0000_0700, '0, waited);
    chk("post_rst_d_latency", waited, 1);
    respond("post_rst_d", 1'b1, {32{8'hC3}});
    bus.d_pmem_read = 1'b0;
    tick();

    // Spurious memory response while idle.
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {32{8'hEE}};
    #1;
    chk("spurious_resps", {bus.i_pmem_resp, bus.d_pmem_resp}, 2'b00);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("spurious_state", dut.state, IDLE);
    chk("spurious_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
